// File: rtl/vending_pkg.sv
// Shared definitions for the change dispenser: amount width, coin values,
// coin_sel encoding and the dispenser state enum.
package vending_pkg;

  localparam int AMT_W = 5;

  localparam logic [AMT_W-1:0] COIN_L = 5'd10;
  localparam logic [AMT_W-1:0] COIN_M = 5'd5;
  localparam logic [AMT_W-1:0] COIN_S = 5'd1;

  typedef enum logic [1:0] {
    CSEL_NONE = 2'b00,
    CSEL_S    = 2'b01,
    CSEL_M    = 2'b10,
    CSEL_L    = 2'b11
  } coin_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_EJECT  = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  function automatic logic [AMT_W-1:0] coin_worth(input coin_sel_e sel);
    case (sel)
      CSEL_L:  coin_worth = COIN_L;
      CSEL_M:  coin_worth = COIN_M;
      CSEL_S:  coin_worth = COIN_S;
      default: coin_worth = '0;
    endcase
  endfunction

endpackage

// File: rtl/coin_selector.sv
// Greedy coin choice: largest coin that fits the remaining amount and whose
// tube is not empty. no_coin flags that nothing usable is available.
module coin_selector
  import vending_pkg::*;
(
  input  logic [AMT_W-1:0] remaining,
  input  logic [2:0]       tube_empty,
  output coin_sel_e        coin_sel,
  output logic [AMT_W-1:0] coin_value,
  output logic             no_coin
);

  // Priority pick from large to small
  always_comb begin
    coin_sel = CSEL_NONE;
    no_coin  = 1'b0;
    if (remaining >= COIN_L && !tube_empty[2]) begin
      coin_sel = CSEL_L;
    end else if (remaining >= COIN_M && !tube_empty[1]) begin
      coin_sel = CSEL_M;
    end else if (remaining >= COIN_S && !tube_empty[0]) begin
      coin_sel = CSEL_S;
    end else begin
      no_coin = 1'b1;
    end
    coin_value = coin_worth(coin_sel);
  end

endmodule

// File: rtl/change_dispenser.sv
// Vend/refund controller: computes change, then pays it out one coin at a
// time over a valid/ack handshake with an ack timeout leading to FAULT.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vend_req,
  input  logic             cancel,
  input  logic [AMT_W-1:0] current_amount,
  input  logic [AMT_W-1:0] product_price,
  input  logic [2:0]       tube_empty,
  input  logic             coin_ack,
  input  logic             fault_clr,
  output logic             coin_valid,
  output logic [1:0]       coin_sel,
  output logic             product_release,
  output logic             done,
  output logic             busy,
  output logic             insufficient,
  output logic             fault,
  output logic [AMT_W-1:0] remaining
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [AMT_W-1:0] coin_val_q, coin_val_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  coin_sel_e        coin_sel_q, coin_sel_d;
  logic             coin_valid_q, coin_valid_d;
  logic             release_q, release_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             insuf_q, insuf_d;
  logic             fault_q, fault_d;

  coin_sel_e        sel_coin_s;
  logic [AMT_W-1:0] sel_value_s;
  logic             no_coin_s;

  coin_selector u_sel (
    .remaining  (remaining_q),
    .tube_empty (tube_empty),
    .coin_sel   (sel_coin_s),
    .coin_value (sel_value_s),
    .no_coin    (no_coin_s)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    coin_val_d   = coin_val_q;
    cnt_d        = cnt_q;
    coin_sel_d   = coin_sel_q;
    coin_valid_d = coin_valid_q;
    release_d    = 1'b0;
    done_d       = 1'b0;
    insuf_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        coin_valid_d = 1'b0;
        coin_sel_d   = CSEL_NONE;
        cnt_d        = '0;
        if (cancel) begin
          if (current_amount != '0) begin
            remaining_d = current_amount;
            state_d     = ST_SELECT;
          end else begin
            state_d = ST_DONE;
          end
        end else if (vend_req) begin
          if (current_amount < product_price) begin
            insuf_d = 1'b1;
          end else begin
            remaining_d = current_amount - product_price;
            release_d   = 1'b1;
            state_d     = ST_SELECT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SELECT: begin
        cnt_d = '0;
        if (remaining_q == '0) begin
          state_d = ST_DONE;
        end else if (no_coin_s) begin
          state_d = ST_FAULT;
        end else begin
          coin_valid_d = 1'b1;
          coin_sel_d   = sel_coin_s;
          coin_val_d   = sel_value_s;
          state_d      = ST_EJECT;
        end
      end
      ST_EJECT: begin
        // The chosen coin never exceeds remaining, so this cannot underflow
        if (coin_ack) begin
          remaining_d  = remaining_q - coin_val_q;
          coin_valid_d = 1'b0;
          coin_sel_d   = CSEL_NONE;
          state_d      = ST_SELECT;
        end else if (cnt_q == CNT_LAST) begin
          coin_valid_d = 1'b0;
          coin_sel_d   = CSEL_NONE;
          state_d      = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (fault_clr) begin
          remaining_d = '0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        remaining_d  = '0;
        coin_valid_d = 1'b0;
        coin_sel_d   = CSEL_NONE;
      end
    endcase
    done_d  = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE);
    fault_d = (state_d == ST_FAULT);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      coin_val_q   <= '0;
      cnt_q        <= '0;
      coin_sel_q   <= CSEL_NONE;
      coin_valid_q <= 1'b0;
      release_q    <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      insuf_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      coin_val_q   <= coin_val_d;
      cnt_q        <= cnt_d;
      coin_sel_q   <= coin_sel_d;
      coin_valid_q <= coin_valid_d;
      release_q    <= release_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      insuf_q      <= insuf_d;
      fault_q      <= fault_d;
    end
  end

  assign coin_valid      = coin_valid_q;
  assign coin_sel        = coin_sel_q;
  assign product_release = release_q;
  assign done            = done_q;
  assign busy            = busy_q;
  assign insufficient    = insuf_q;
  assign fault           = fault_q;
  assign remaining       = remaining_q;

endmodule
